// File: rtl/tia_biphase_decoder.sv
// -----------------------------------------------------------------------------
// tia_biphase_decoder
//
// Lock/health monitor for the TIA two-phase clock pair. The (phi1,phi2) pair
// is sampled once per master clock and must follow the repeating 4-sample
// sequence (1,0) (0,0) (0,1) (0,0). The decoder hunts for the sequence,
// confirms LOCK_PERIODS clean periods, then reports the sequence position and
// per-phase strobes in the master clock domain. Overlap and sequence faults
// are flagged and counted.
//
// Ports
//   clk          in   master clock, rising edge
//   r            in   asynchronous active-high reset
//   phi1, phi2   in   biphase clock pair, synchronous to clk
//   locked       out  decoder is in LOCKED
//   phase        out  position of the last evaluated sample, 0 when unlocked
//   phi1_stb     out  one-clock pulse per locked (1,0) sample
//   phi2_stb     out  one-clock pulse per locked (0,1) sample
//   err          out  one-clock fault pulse
//   err_count    out  saturating fault counter
//   period_count out  wrapping count of locked periods
// -----------------------------------------------------------------------------
module tia_biphase_decoder #(
   parameter int LOCK_PERIODS = 2,
   parameter int ERR_W        = 8,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             r,
   input  logic             phi1,
   input  logic             phi2,
   output logic             locked,
   output logic [1:0]       phase,
   output logic             phi1_stb,
   output logic             phi2_stb,
   output logic             err,
   output logic [ERR_W-1:0] err_count,
   output logic [CNT_W-1:0] period_count
);

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      CONFIRM = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   localparam logic [3:0]       LOCK_C  = 4'(LOCK_PERIODS);
   localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

   // Legal (phi1,phi2) sample for a given sequence position.
   function automatic logic [1:0] sample_at(input logic [1:0] p);
      logic [1:0] v;
      case (p)
         2'd0:    v = 2'b10;
         2'd1:    v = 2'b00;
         2'd2:    v = 2'b01;
         2'd3:    v = 2'b00;
         default: v = 2'b00;
      endcase
      return v;
   endfunction

   state_t     state_r, state_s;
   logic       s1_r, s2_r;
   logic [1:0] pos_r, pos_s;
   logic [3:0] c_r, c_s;
   logic [1:0] exp_pos_s;
   logic       match_s;
   logic       start_s;
   logic       stb1_s, stb2_s, err_s;

   // Next-state, position, good-period count and pulse decode.
   always_comb begin
      state_s   = state_r;
      pos_s     = pos_r;
      c_s       = c_r;
      stb1_s    = 1'b0;
      stb2_s    = 1'b0;
      err_s     = 1'b0;
      exp_pos_s = pos_r + 2'd1;
      match_s   = ({s1_r, s2_r} == sample_at(exp_pos_s));
      start_s   = ({s1_r, s2_r} == 2'b10);

      if (s1_r && s2_r) begin
         // Overlap beats every other rule, whatever the state.
         err_s   = 1'b1;
         state_s = SEARCH;
         pos_s   = 2'd0;
         c_s     = 4'd0;
      end else begin
         case (state_r)
            SEARCH: begin
               if (start_s) begin
                  state_s = CONFIRM;
                  pos_s   = 2'd0;
                  c_s     = 4'd0;
               end else begin
                  state_s = SEARCH;
               end
            end
            CONFIRM: begin
               if (match_s) begin
                  pos_s = exp_pos_s;
                  if (exp_pos_s == 2'd0) begin
                     c_s = c_r + 4'd1;
                     if ((c_r + 4'd1) == LOCK_C) begin
                        state_s = LOCKED;
                     end else begin
                        state_s = CONFIRM;
                     end
                  end else begin
                     state_s = CONFIRM;
                  end
               end else if (start_s) begin
                  // A fresh (1,0) restarts confirmation silently.
                  state_s = CONFIRM;
                  pos_s   = 2'd0;
                  c_s     = 4'd0;
               end else begin
                  state_s = SEARCH;
                  pos_s   = 2'd0;
                  c_s     = 4'd0;
               end
            end
            LOCKED: begin
               if (match_s) begin
                  pos_s  = exp_pos_s;
                  stb1_s = (exp_pos_s == 2'd0);
                  stb2_s = (exp_pos_s == 2'd2);
               end else begin
                  err_s = 1'b1;
                  pos_s = 2'd0;
                  c_s   = 4'd0;
                  if (start_s) begin
                     state_s = CONFIRM;
                  end else begin
                     state_s = SEARCH;
                  end
               end
            end
            default: begin
               state_s = SEARCH;
               pos_s   = 2'd0;
               c_s     = 4'd0;
            end
         endcase
      end
   end

   // Input capture, FSM state and registered outputs.
   always_ff @(posedge clk or posedge r) begin
      if (r) begin
         s1_r         <= 1'b0;
         s2_r         <= 1'b0;
         state_r      <= SEARCH;
         pos_r        <= 2'd0;
         c_r          <= 4'd0;
         locked       <= 1'b0;
         phase        <= 2'd0;
         phi1_stb     <= 1'b0;
         phi2_stb     <= 1'b0;
         err          <= 1'b0;
         err_count    <= '0;
         period_count <= '0;
      end else begin
         s1_r     <= phi1;
         s2_r     <= phi2;
         state_r  <= state_s;
         pos_r    <= pos_s;
         c_r      <= c_s;
         locked   <= (state_s == LOCKED);
         phase    <= (state_s == LOCKED) ? pos_s : 2'd0;
         phi1_stb <= stb1_s;
         phi2_stb <= stb2_s;
         err      <= err_s;
         // Counter sticks at all-ones; err keeps pulsing regardless.
         if (err_s && (err_count != ERR_MAX)) begin
            err_count <= err_count + ERR_W'(1);
         end else begin
            err_count <= err_count;
         end
         if (stb1_s) begin
            period_count <= period_count + CNT_W'(1);
         end else begin
            period_count <= period_count;
         end
      end
   end

endmodule

// File: tb/tb_tia_biphase_decoder.sv
// -----------------------------------------------------------------------------
// tb_tia_biphase_decoder
//
// Directed bench for tia_biphase_decoder (LOCK_PERIODS=2, ERR_W=2, CNT_W=4).
// Stimulus drives one (phi1,phi2) sample per clock and, for every sample
// expected to produce a visible event (strobe, err, or locked change), queues
// the expected output word tagged with the edge after which it must appear.
// A separate monitor pops and compares whenever the DUT shows such an event.
// -----------------------------------------------------------------------------
module tb_tia_biphase_decoder;

   logic       clk;
   logic       r;
   logic       phi1;
   logic       phi2;
   logic       locked;
   logic [1:0] phase;
   logic       phi1_stb;
   logic       phi2_stb;
   logic       err;
   logic [1:0] err_count;
   logic [3:0] period_count;

   tia_biphase_decoder #(
      .LOCK_PERIODS(2),
      .ERR_W       (2),
      .CNT_W       (4)
   ) dut (
      .clk         (clk),
      .r           (r),
      .phi1        (phi1),
      .phi2        (phi2),
      .locked      (locked),
      .phase       (phase),
      .phi1_stb    (phi1_stb),
      .phi2_stb    (phi2_stb),
      .err         (err),
      .err_count   (err_count),
      .period_count(period_count)
   );

   typedef struct {
      int          e;
      logic [11:0] v;
   } exp_t;

   exp_t        exp_q[$];
   int          n_cmp  = 0;
   int          n_bad  = 0;
   int          edge_n = 0;
   logic [1:0]  ec;
   logic [3:0]  pc;
   logic        prev_locked;
   logic [11:0] got;
   exp_t        e_m;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Edge index: edge 1 is the first rising edge after reset release.
   initial begin
      forever begin
         @(posedge clk);
         if (r) edge_n = 0;
         else   edge_n = edge_n + 1;
      end
   end

   function automatic logic [11:0] mk(input logic l, input logic [1:0] ph,
                                      input logic s1, input logic s2,
                                      input logic er, input logic [1:0] c_e,
                                      input logic [3:0] c_p);
      return {l, ph, s1, s2, er, c_e, c_p};
   endfunction

   task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] need);
      n_cmp++;
      if (g !== need) begin
         n_bad++;
         $display("FAIL %s: got %h need %h", nm, g, need);
      end
   endtask

   // Monitor: compare on every strobe, err, or change of locked.
   initial begin
      prev_locked = 1'b0;
      forever begin
         @(negedge clk);
         if (r) begin
            prev_locked = 1'b0;
         end else begin
            got = {locked, phase, phi1_stb, phi2_stb, err, err_count, period_count};
            if (phi1_stb || phi2_stb || err || (locked != prev_locked)) begin
               n_cmp++;
               if (exp_q.size() == 0) begin
                  n_bad++;
                  $display("FAIL event: unexpected output %h after edge %0d, need no event", got, edge_n);
               end else begin
                  e_m = exp_q.pop_front();
                  if ((e_m.e != edge_n) || (e_m.v !== got)) begin
                     n_bad++;
                     $display("FAIL event: got %h after edge %0d, need %h after edge %0d",
                              got, edge_n, e_m.v, e_m.e);
                  end
               end
            end
            prev_locked = locked;
         end
      end
   end

   // One sample per clock; an expected event shows up two edges later.
   task automatic smp(input logic p1, input logic p2, input bit ev, input logic [11:0] ex);
      exp_t x;
      phi1 = p1;
      phi2 = p2;
      if (ev) begin
         x.e = edge_n + 2;
         x.v = ex;
         exp_q.push_back(x);
      end
      @(negedge clk);
   endtask

   task automatic quiet(input logic p1, input logic p2);
      smp(p1, p2, 1'b0, 12'h000);
   endtask

   // From CONFIRM at pos0: two clean periods, locking on the closing (1,0).
   task automatic confirm_rest();
      quiet(1'b0, 1'b0); quiet(1'b0, 1'b1); quiet(1'b0, 1'b0); quiet(1'b1, 1'b0);
      quiet(1'b0, 1'b0); quiet(1'b0, 1'b1); quiet(1'b0, 1'b0);
      smp(1'b1, 1'b0, 1'b1, mk(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, ec, pc));
   endtask

   task automatic lock_seq();
      quiet(1'b1, 1'b0);
      confirm_rest();
   endtask

   // One locked period starting from pos0.
   task automatic lperiod();
      quiet(1'b0, 1'b0);
      smp(1'b0, 1'b1, 1'b1, mk(1'b1, 2'd2, 1'b0, 1'b1, 1'b0, ec, pc));
      quiet(1'b0, 1'b0);
      pc = pc + 4'd1;
      smp(1'b1, 1'b0, 1'b1, mk(1'b1, 2'd0, 1'b1, 1'b0, 1'b0, ec, pc));
   endtask

   task automatic fault(input logic p1, input logic p2);
      if (ec != 2'd3) ec = ec + 2'd1;
      smp(p1, p2, 1'b1, mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, ec, pc));
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout need completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      r    = 1'b1;
      phi1 = 1'b1;
      phi2 = 1'b0;
      ec   = 2'd0;
      pc   = 4'd0;
      repeat (2) @(negedge clk);
      chk("reset_state", {20'd0, locked, phase, phi1_stb, phi2_stb, err, err_count, period_count}, 32'd0);
      r = 1'b0;

      // Clean lock: locked after edge 10, phi2_stb after 12, phi1_stb after 14.
      lock_seq();
      repeat (3) lperiod();

      // Overlap while locked.
      quiet(1'b0, 1'b0);
      fault(1'b1, 1'b1);
      quiet(1'b0, 1'b0);
      lock_seq();

      // Skipped (0,1).
      quiet(1'b0, 1'b0);
      fault(1'b0, 1'b0);
      quiet(1'b0, 1'b0);
      lock_seq();

      // Early (1,0) at pos2 goes straight back to CONFIRM.
      quiet(1'b0, 1'b0);
      fault(1'b1, 1'b0);
      confirm_rest();
      lperiod();

      // Async reset between edges while locked.
      quiet(1'b0, 1'b0);
      chk("locked_before_reset", {31'd0, locked}, 32'd1);
      phi1 = 1'b1;
      phi2 = 1'b0;
      #2;
      r = 1'b1;
      #1;
      chk("async_reset", {20'd0, locked, phase, phi1_stb, phi2_stb, err, err_count, period_count}, 32'd0);
      repeat (2) @(negedge clk);
      r  = 1'b0;
      ec = 2'd0;
      pc = 4'd0;
      lock_seq();

      // Five overlaps: err_count 1,2,3,3,3.
      repeat (5) fault(1'b1, 1'b1);
      quiet(1'b0, 1'b0);
      lock_seq();

      // 17 locked periods wrap a 4-bit counter to 1.
      repeat (17) lperiod();
      quiet(1'b0, 1'b0);
      chk("period_wrap", {28'd0, period_count}, 32'd1);
      chk("drain", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/tia_biphase_decoder.md
# tia_biphase_decoder

Receive-side checker for the TIA two-phase clock pair. Samples `phi1`/`phi2` on the master `clk`, locks onto the 4-clock biphase sequence, and reports phase position and per-phase strobes for logic that consumes the biphase domain from the master clock. It also flags and counts overlap and sequence faults. It sits beside each biphase clock generator instance as a lock/health monitor and as a source of master-clock-domain phase enables.

## Interface
Parameters:
- `LOCK_PERIODS`, default 2: number of consecutive complete, correct periods needed to assert `locked`; legal range 1..15.
- `ERR_W`, default 8: width of `err_count`.
- `CNT_W`, default 16: width of `period_count`.

Ports:
- `clk` input 1: master clock; all state updates on the rising edge.
- `r` input 1: reset. One clock; reset is asynchronous and active-high.
- `phi1` input 1: biphase clock 1, synchronous to `clk`.
- `phi2` input 1: biphase clock 2, synchronous to `clk`.
- `locked` output 1: decoder is in LOCKED.
- `phase` output 2: sequence position of the last evaluated sample; 0 when not locked.
- `phi1_stb` output 1: one-clock pulse for each locked (1,0) sample.
- `phi2_stb` output 1: one-clock pulse for each locked (0,1) sample.
- `err` output 1: one-clock fault pulse.
- `err_count` output ERR_W: saturating fault counter.
- `period_count` output CNT_W: wrapping count of locked periods.

## Operation
- Legal sample sequence of (phi1,phi2), one sample per clk:
  - pos0 = (1,0), pos1 = (0,0), pos2 = (0,1), pos3 = (0,0), then back to pos0.
- Input stage: `phi1`/`phi2` are registered once into `s1`/`s2`. The FSM evaluates `s1`/`s2`.
- FSM states: SEARCH, CONFIRM, LOCKED. Internal registers: position `pos[1:0]` and good-period counter `c[3:0]`.
- SEARCH:
  - Sample (1,0) -> CONFIRM, pos=0, c=0.
  - Any other sample -> stay in SEARCH.
- CONFIRM, sample matches expected pos+1 (mod 4):
  - Advance pos.
  - When the match is a pos0 sample, increment c.
  - If c reaches LOCK_PERIODS -> LOCKED.
- CONFIRM, mismatch: no error is reported.
  - Sample (1,0) -> restart CONFIRM, pos=0, c=0.
  - Otherwise -> SEARCH.
- LOCKED, sample matches:
  - Advance pos.
  - On a pos0 sample: `phi1_stb`=1 and `period_count`+1 (wraps at 2^CNT_W).
  - On a pos2 sample: `phi2_stb`=1.
- LOCKED, mismatch: `err`=1 and `err_count`+1.
  - Sample (1,0) -> CONFIRM, pos=0, c=0.
  - Otherwise -> SEARCH.
- Overlap sample (1,1), in any state:
  - `err`=1, `err_count`+1, next state SEARCH.
  - Takes priority over all other rules.
- Strobes only fire when the state was LOCKED before the sample. The sample that causes locking raises `locked` but produces no strobe and no `period_count` increment.
- `err_count` saturates at 2^ERR_W-1 and never wraps. `err` still pulses when saturated.
- `phase` reflects pos while LOCKED and is forced to 0 otherwise.
- A stalled clock pair (e.g. stuck at (0,0)) shows up as a mismatch at the next expected non-(0,0) position.

## Timing
- All outputs are registered.
- Latency: a value on `phi1`/`phi2` before clk edge k is captured at edge k and evaluated at edge k+1. Outputs reflect it after edge k+1 (2-edge latency).
- Reset (asynchronous, immediate) sets:
  - `s1`=`s2`=0, state=SEARCH, pos=0, c=0.
  - `locked`=0, `phase`=0, `phi1_stb`=0, `phi2_stb`=0, `err`=0, `err_count`=0, `period_count`=0.
- Reset asserted mid-lock: all outputs drop on assertion, with no `err` pulse.
- After reset release, the first evaluated sample is the one captured at the first edge after release.
- The generator holds (1,0) during its own reset. With LOCK_PERIODS=2, `locked` rises 8 samples after the first captured (1,0).

## Test plan
- Clean sequence after reset, LOCK_PERIODS=2: first (1,0) evaluated at edge 2.
  - Required: `locked`=1 after edge 10.
  - Required: first `phi1_stb` after edge 14, with `period_count`=1; `phi2_stb` after edge 12 and every 4 clocks after that.
  - Required: `err` never asserts.
- Overlap: while locked, inject one (1,1) sample.
  - Required: `err` pulses for exactly 1 clock, `err_count`=1, `locked`=0, `phase`=0.
  - Required: relock 8 samples after the next (1,0).
- Skipped phase: while locked, replace one (0,1) with (0,0).
  - Required: `err` pulse, `err_count`+1, SEARCH; no `phi2_stb` for that period.
- Early restart: while locked, present (1,0) at pos2.
  - Required: `err` pulse, immediate CONFIRM at pos0; relock after 2 further correct periods.
- Saturation with ERR_W=2: inject 5 overlap faults.
  - Required: `err_count` reads 1,2,3,3,3 and `err` pulses 5 times.
  - Separately run `period_count` with CNT_W=4 for 17 locked periods: required reading 1.
- Async reset mid-lock: assert `r` between edges.
  - Required: all outputs are 0 before the next edge.
  - Required: no `err` pulse after release; relock on the clean sequence.
